l2cache_prefetcher: RTL and testbench

L2CACHE_PREFETCHER -- requirements
Module: l2cache_prefetcher

---
 rtl/l2cache_prefetcher.sv | 188 ++++++++++++++++++
 tb/tb_l2cache_prefetcher.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/l2cache_prefetcher.sv
// L2 prefetcher: trains a next-line predictor on I-side fetches and a stride
// predictor on D-side reads, queues line candidates and issues them to L2 one at a time.
module l2cache_prefetcher #(
  parameter int offset_width = 3,
  parameter int depth        = 4
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        pref_en,
  input  logic        icache_l2cache_req,
  input  logic [31:0] addr_icache_l2cache,
  input  logic        l2cache_icache_addrOK,
  input  logic        icache_l2cache_SUC,
  input  logic        dcache_l2cache_req,
  input  logic [31:0] addr_dcache_l2cache,
  input  logic        dcache_l2cache_wr,
  input  logic        dcache_l2cache_SUC,
  input  logic        l2cache_dcache_addrOK,
  output logic        req_pref_l2cache,
  output logic        type_pref_l2cache,
  output logic [31:0] addr_pref_l2cache,
  input  logic        hit_l2cache_pref,
  input  logic        miss_l2cache_pref,
  input  logic        complete_l2cache_pref,
  output logic [31:0] pref_issue_cnt
);

  // state  | meaning
  // S_IDLE | no prefetch outstanding; pops the queue head when one is present
  // S_REQ  | request presented to L2, waiting for hit/miss
  // S_WAIT | L2 refilling the missed line, waiting for complete
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

  localparam int LOW = offset_width + 2;
  localparam int LW  = 32 - LOW;
  localparam int PW  = $clog2(depth);
  localparam logic [PW:0] DEPTH_C = (PW+1)'(depth);

  state_t state;

  logic [LW-1:0] last_iline, last_dline, stride;
  logic [1:0]    conf;
  logic [31:0]   last_addr;
  logic          last_valid;

  logic [31:0]   q_addr [depth];
  logic          q_type [depth];
  logic [PW-1:0] rd_ptr, wr_ptr, wr_ptr_i;
  logic [PW:0]   count, free;

  logic          i_event, d_event;
  logic [LW-1:0] i_line, d_line, delta, stride_nxt, i_cand_line, d_cand_line;
  logic [31:0]   i_cand, d_cand;
  logic          d_match;
  logic [1:0]    conf_nxt;
  logic          i_ok, d_ok, i_dup, d_dup, i_enq, d_enq, pop;
  logic          unused_bits;

  assign unused_bits = ^{addr_icache_l2cache[LOW-1:0], addr_dcache_l2cache[LOW-1:0]};

  assign i_event = icache_l2cache_req & l2cache_icache_addrOK & ~icache_l2cache_SUC & pref_en;
  assign d_event = dcache_l2cache_req & l2cache_dcache_addrOK & ~dcache_l2cache_wr
                   & ~dcache_l2cache_SUC & pref_en;

  assign i_line      = addr_icache_l2cache[31:LOW];
  assign d_line      = addr_dcache_l2cache[31:LOW];
  assign i_cand_line = i_line + LW'(1);
  assign i_cand      = {i_cand_line, {LOW{1'b0}}};

  assign delta      = d_line - last_dline;
  assign d_match    = (delta == stride) && (delta != '0);
  assign stride_nxt = d_match ? stride : delta;
  assign d_cand_line = d_line + stride_nxt;
  assign d_cand      = {d_cand_line, {LOW{1'b0}}};

  always_comb begin
    conf_nxt = 2'd0;
    if (d_match) conf_nxt = (conf == 2'd3) ? 2'd3 : conf + 2'd1;
  end

  assign pop  = pref_en && (state == S_IDLE) && (count != '0);
  // A same-cycle pop frees its slot for this cycle's enqueues.
  assign free = DEPTH_C - count + (PW+1)'(pop);

  assign d_dup = last_valid && (d_cand == last_addr);
  assign d_ok  = d_event && (conf_nxt >= 2'd2) && !d_dup
                 && (d_cand[31:12] == addr_dcache_l2cache[31:12]);
  assign d_enq = d_ok && (free != '0);

  // The D candidate goes in first, so it is what the I candidate must not repeat.
  assign i_dup = d_enq ? (i_cand == d_cand) : (last_valid && (i_cand == last_addr));
  assign i_ok  = i_event && (i_line != last_iline) && !i_dup
                 && (i_cand[31:12] == addr_icache_l2cache[31:12]);
  assign i_enq = i_ok && (free > (PW+1)'(d_enq));

  assign wr_ptr_i = wr_ptr + PW'(d_enq);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      last_iline <= '0;
      last_dline <= '0;
      stride     <= '0;
      conf       <= 2'd0;
      last_addr  <= '0;
      last_valid <= 1'b0;
    end else begin
      if (i_event && (i_line != last_iline)) last_iline <= i_line;
      if (d_event) begin
        last_dline <= d_line;
        stride     <= stride_nxt;
        conf       <= conf_nxt;
      end
      if (i_enq) begin
        last_addr  <= i_cand;
        last_valid <= 1'b1;
      end else if (d_enq) begin
        last_addr  <= d_cand;
        last_valid <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (!pref_en) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      rd_ptr <= rd_ptr + PW'(pop);
      wr_ptr <= wr_ptr + PW'(d_enq) + PW'(i_enq);
      count  <= count + (PW+1)'(d_enq) + (PW+1)'(i_enq) - (PW+1)'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (d_enq) begin
      q_addr[wr_ptr] <= d_cand;
      q_type[wr_ptr] <= 1'b1;
    end
    if (i_enq) begin
      q_addr[wr_ptr_i] <= i_cand;
      q_type[wr_ptr_i] <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state             <= S_IDLE;
      req_pref_l2cache  <= 1'b0;
      type_pref_l2cache <= 1'b0;
      addr_pref_l2cache <= '0;
      pref_issue_cnt    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (pop) begin
            addr_pref_l2cache <= q_addr[rd_ptr];
            type_pref_l2cache <= q_type[rd_ptr];
            req_pref_l2cache  <= 1'b1;
            state             <= S_REQ;
          end
        end
        S_REQ: begin
          if (hit_l2cache_pref) begin
            req_pref_l2cache <= 1'b0;
            state            <= S_IDLE;
          end else if (miss_l2cache_pref) begin
            req_pref_l2cache <= 1'b0;
            pref_issue_cnt   <= pref_issue_cnt + 32'd1;
            state            <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (complete_l2cache_pref) state <= S_IDLE;
        end
        default: begin
          req_pref_l2cache <= 1'b0;
          state            <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_l2cache_prefetcher.sv
// Directed bench for l2cache_prefetcher: a per-cycle vector table followed by
// hand-written sequences for queue fill, same-cycle arbitration, flush and reset.
module tb_l2cache_prefetcher;

  logic        clk = 1'b0;
  logic        rstn, pref_en;
  logic        icache_l2cache_req, l2cache_icache_addrOK, icache_l2cache_SUC;
  logic [31:0] addr_icache_l2cache, addr_dcache_l2cache;
  logic        dcache_l2cache_req, dcache_l2cache_wr, dcache_l2cache_SUC, l2cache_dcache_addrOK;
  logic        req_pref_l2cache, type_pref_l2cache;
  logic [31:0] addr_pref_l2cache, pref_issue_cnt;
  logic        hit_l2cache_pref, miss_l2cache_pref, complete_l2cache_pref;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  l2cache_prefetcher #(.offset_width(3), .depth(4)) dut (
    .clk                   (clk),
    .rstn                  (rstn),
    .pref_en               (pref_en),
    .icache_l2cache_req    (icache_l2cache_req),
    .addr_icache_l2cache   (addr_icache_l2cache),
    .l2cache_icache_addrOK (l2cache_icache_addrOK),
    .icache_l2cache_SUC    (icache_l2cache_SUC),
    .dcache_l2cache_req    (dcache_l2cache_req),
    .addr_dcache_l2cache   (addr_dcache_l2cache),
    .dcache_l2cache_wr     (dcache_l2cache_wr),
    .dcache_l2cache_SUC    (dcache_l2cache_SUC),
    .l2cache_dcache_addrOK (l2cache_dcache_addrOK),
    .req_pref_l2cache      (req_pref_l2cache),
    .type_pref_l2cache     (type_pref_l2cache),
    .addr_pref_l2cache     (addr_pref_l2cache),
    .hit_l2cache_pref      (hit_l2cache_pref),
    .miss_l2cache_pref     (miss_l2cache_pref),
    .complete_l2cache_pref (complete_l2cache_pref),
    .pref_issue_cnt        (pref_issue_cnt)
  );

  typedef struct {
    logic        ie;
    logic [31:0] ia;
    logic        isuc;
    logic        de;
    logic [31:0] da;
    logic        dwr;
    logic        ok;
    logic        hit;
    logic        miss;
    logic        cmp;
    logic        en;
    logic        xreq;
    logic        xtype;
    logic [31:0] xaddr;
    logic [31:0] xcnt;
  } vec_t;

  vec_t vec [36];

  function automatic vec_t mk(input logic ie, input logic [31:0] ia, input logic isuc,
                              input logic de, input logic [31:0] da, input logic dwr,
                              input logic ok, input logic hit, input logic miss,
                              input logic cmp, input logic en, input logic xreq,
                              input logic xtype, input logic [31:0] xaddr,
                              input logic [31:0] xcnt);
    vec_t v;
    v.ie = ie; v.ia = ia; v.isuc = isuc; v.de = de; v.da = da; v.dwr = dwr;
    v.ok = ok; v.hit = hit; v.miss = miss; v.cmp = cmp; v.en = en;
    v.xreq = xreq; v.xtype = xtype; v.xaddr = xaddr; v.xcnt = xcnt;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    pref_en = 1'b1;
    icache_l2cache_req = 1'b0; addr_icache_l2cache = '0; l2cache_icache_addrOK = 1'b0;
    icache_l2cache_SUC = 1'b0;
    dcache_l2cache_req = 1'b0; addr_dcache_l2cache = '0; l2cache_dcache_addrOK = 1'b0;
    dcache_l2cache_wr = 1'b0; dcache_l2cache_SUC = 1'b0;
    hit_l2cache_pref = 1'b0; miss_l2cache_pref = 1'b0; complete_l2cache_pref = 1'b0;
  endtask

  task automatic drive_i(input logic [31:0] a);
    icache_l2cache_req = 1'b1; l2cache_icache_addrOK = 1'b1; addr_icache_l2cache = a;
  endtask

  task automatic drive_d(input logic [31:0] a);
    dcache_l2cache_req = 1'b1; l2cache_dcache_addrOK = 1'b1; addr_dcache_l2cache = a;
  endtask

  // Waits (bounded) for a request, checks it against the expected entry, then acks with hit.
  task automatic expect_issue(input string name, input logic [31:0] ea, input logic et);
    for (int n = 0; n < 8 && !req_pref_l2cache; n++) cyc();
    chk({name, "_req"}, 32'(req_pref_l2cache), 32'd1);
    chk({name, "_addr"}, addr_pref_l2cache, ea);
    chk({name, "_type"}, 32'(type_pref_l2cache), 32'(et));
    hit_l2cache_pref = 1'b1;
    cyc();
    hit_l2cache_pref = 1'b0;
  endtask

  task automatic expect_quiet(input string name, input int cycles);
    int hi;
    hi = 0;
    for (int n = 0; n < cycles; n++) begin
      if (req_pref_l2cache) hi++;
      cyc();
    end
    chk(name, 32'(hi), 32'd0);
  endtask

  initial begin
    logic [31:0] exp_cnt;

    vec[0]  = mk(1, 32'h1000_0040, 0, 0, 0, 0, 1, 0, 0, 0, 1,  0, 0, 0, 0);
    vec[1]  = mk(1, 32'h1000_0044, 0, 0, 0, 0, 1, 0, 0, 0, 1,  1, 0, 32'h1000_0060, 0);
    vec[2]  = mk(0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 1,               0, 0, 0, 0);
    vec[3]  = mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1,               0, 0, 0, 0);
    vec[4]  = mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1,               0, 0, 0, 0);
    vec[5]  = mk(0, 0, 0, 1, 32'h0000_2000, 0, 1, 0, 0, 0, 1,  0, 0, 0, 0);
    vec[6]  = mk(0, 0, 0, 1, 32'h0000_2040, 0, 1, 0, 0, 0, 1,  0, 0, 0, 0);
    vec[7]  = mk(0, 0, 0, 1, 32'h0000_2080, 0, 1, 0, 0, 0, 1,  0, 0, 0, 0);
    vec[8]  = mk(0, 0, 0, 1, 32'h0000_20C0, 0, 1, 0, 0, 0, 1,  0, 0, 0, 0);
    vec[9]  = mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1,               1, 1, 32'h0000_2100, 0);
    vec[10] = mk(0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 1,               0, 0, 0, 1);
    vec[11] = mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1,               0, 0, 0, 1);
    vec[12] = mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 1,               0, 0, 0, 1);
    vec[13] = mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1,               0, 0, 0, 1);
    vec[14] = mk(0, 0, 0, 1, 32'h0000_2100, 1, 1, 0, 0, 0, 1,  0, 0, 0, 1);
    vec[15] = mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1,               0, 0, 0, 1);
    vec[16] = mk(0, 0, 0, 1, 32'h0000_2100, 0, 1, 0, 0, 0, 1,  0, 0, 0, 1);
    vec[17] = mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1,               1, 1, 32'h0000_2140, 1);
    vec[18] = mk(0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 1,               0, 0, 0, 1);
    vec[19] = mk(1, 32'h0000_0FE0, 0, 0, 0, 0, 1, 0, 0, 0, 1,  0, 0, 0, 1);
    vec[20] = mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1,               0, 0, 0, 1);
    vec[21] = mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1,               0, 0, 0, 1);
    vec[22] = mk(1, 32'h3000_0000, 1, 0, 0, 0, 1, 0, 0, 0, 1,  0, 0, 0, 1);
    vec[23] = mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1,               0, 0, 0, 1);
    vec[24] = mk(1, 32'h3000_0100, 0, 0, 0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 1);
    vec[25] = mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1,               0, 0, 0, 1);
    vec[26] = mk(1, 32'h3000_0200, 0, 0, 0, 0, 1, 0, 0, 0, 0,  0, 0, 0, 1);
    vec[27] = mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1,               0, 0, 0, 1);
    vec[28] = mk(1, 32'h3000_0200, 0, 0, 0, 0, 1, 0, 0, 0, 1,  0, 0, 0, 1);
    vec[29] = mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1,               1, 0, 32'h3000_0220, 1);
    vec[30] = mk(0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 1,               0, 0, 0, 1);
    vec[31] = mk(0, 0, 0, 1, 32'h0000_2140, 0, 1, 0, 0, 0, 1,  0, 0, 0, 1);
    vec[32] = mk(1, 32'h0000_2160, 0, 0, 0, 0, 1, 0, 0, 0, 1,  1, 1, 32'h0000_2180, 1);
    vec[33] = mk(0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 1,               0, 0, 0, 1);
    vec[34] = mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1,               0, 0, 0, 1);
    vec[35] = mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1,               0, 0, 0, 1);

    drive_idle();
    rstn = 1'b0;
    repeat (3) cyc();
    rstn = 1'b1;
    cyc();
    chk("rst_req", 32'(req_pref_l2cache), 32'd0);
    chk("rst_type", 32'(type_pref_l2cache), 32'd0);
    chk("rst_addr", addr_pref_l2cache, 32'd0);
    chk("rst_cnt", pref_issue_cnt, 32'd0);

    for (int r = 0; r < 36; r++) begin
      icache_l2cache_req    = vec[r].ie;
      addr_icache_l2cache   = vec[r].ia;
      icache_l2cache_SUC    = vec[r].isuc;
      l2cache_icache_addrOK = vec[r].ok;
      dcache_l2cache_req    = vec[r].de;
      addr_dcache_l2cache   = vec[r].da;
      dcache_l2cache_wr     = vec[r].dwr;
      dcache_l2cache_SUC    = 1'b0;
      l2cache_dcache_addrOK = vec[r].ok;
      hit_l2cache_pref      = vec[r].hit;
      miss_l2cache_pref     = vec[r].miss;
      complete_l2cache_pref = vec[r].cmp;
      pref_en               = vec[r].en;
      cyc();
      chk($sformatf("row%0d_req", r), 32'(req_pref_l2cache), 32'(vec[r].xreq));
      if (vec[r].xreq) begin
        chk($sformatf("row%0d_addr", r), addr_pref_l2cache, vec[r].xaddr);
        chk($sformatf("row%0d_type", r), 32'(type_pref_l2cache), 32'(vec[r].xtype));
      end
      chk($sformatf("row%0d_cnt", r), pref_issue_cnt, vec[r].xcnt);
    end
    drive_idle();
    exp_cnt = 32'd1;

    // Queue fill: one in flight, four queued, sixth candidate dropped; request held stable.
    for (int k = 0; k < 6; k++) begin
      drive_i(32'h4000_0000 + 32'(k) * 32'h100);
      cyc();
      if (k >= 1) begin
        chk($sformatf("fill%0d_req", k), 32'(req_pref_l2cache), 32'd1);
        chk($sformatf("fill%0d_addr", k), addr_pref_l2cache, 32'h4000_0020);
      end
    end
    drive_idle();
    repeat (2) cyc();
    chk("fill_hold_addr", addr_pref_l2cache, 32'h4000_0020);
    for (int k = 0; k < 5; k++)
      expect_issue($sformatf("fill_issue%0d", k), 32'h4000_0020 + 32'(k) * 32'h100, 1'b0);
    expect_quiet("fill_sixth_dropped", 6);

    // Same-cycle I and D candidates with a single free slot.
    drive_d(32'h5000_0000); cyc();
    drive_d(32'h5000_0080); cyc();
    drive_d(32'h5000_0100); cyc();
    drive_idle();
    for (int k = 0; k < 4; k++) begin
      drive_i(32'h6000_0000 + 32'(k) * 32'h100);
      cyc();
    end
    drive_i(32'h6000_0400);
    drive_d(32'h5000_0180);
    cyc();
    drive_idle();
    for (int k = 0; k < 4; k++)
      expect_issue($sformatf("arb_i%0d", k), 32'h6000_0020 + 32'(k) * 32'h100, 1'b0);
    expect_issue("arb_d", 32'h5000_0200, 1'b1);
    expect_quiet("arb_i_dropped", 6);

    // Disabling flushes the queue but lets the in-flight request finish.
    for (int k = 0; k < 3; k++) begin
      drive_i(32'h7000_0000 + 32'(k) * 32'h100);
      cyc();
    end
    drive_idle();
    pref_en = 1'b0;
    cyc();
    chk("flush_inflight_req", 32'(req_pref_l2cache), 32'd1);
    chk("flush_inflight_addr", addr_pref_l2cache, 32'h7000_0020);
    pref_en = 1'b1;
    expect_issue("flush_last", 32'h7000_0020, 1'b0);
    expect_quiet("flush_empty", 6);

    // Reset while waiting on a refill with three entries queued.
    for (int k = 0; k < 4; k++) begin
      drive_i(32'h7100_0000 + 32'(k) * 32'h100);
      cyc();
    end
    drive_idle();
    chk("wait_req_before", 32'(req_pref_l2cache), 32'd1);
    miss_l2cache_pref = 1'b1;
    cyc();
    miss_l2cache_pref = 1'b0;
    exp_cnt = exp_cnt + 32'd1;
    chk("wait_req_low", 32'(req_pref_l2cache), 32'd0);
    chk("wait_cnt", pref_issue_cnt, exp_cnt);
    rstn = 1'b0;
    cyc();
    chk("rst2_req", 32'(req_pref_l2cache), 32'd0);
    chk("rst2_cnt", pref_issue_cnt, 32'd0);
    chk("rst2_addr", addr_pref_l2cache, 32'd0);
    rstn = 1'b1;
    complete_l2cache_pref = 1'b1;
    cyc();
    complete_l2cache_pref = 1'b0;
    expect_quiet("rst2_queue_empty", 6);
    drive_i(32'h7200_0000);
    cyc();
    drive_idle();
    cyc();
    chk("post_rst_req", 32'(req_pref_l2cache), 32'd1);
    chk("post_rst_addr", addr_pref_l2cache, 32'h7200_0020);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
